// File: rtl/ccg_harness_pkg.sv
// ============================================================================
// Module  : ccg_harness_pkg
// Purpose : Shared types and constants for the CCGRCG response harness.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ccg_harness_pkg;

   localparam int          OUT_W    = 18;
   localparam int          SIG_W    = 32;
   localparam int          CNT_W    = 16;
   localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] DEF_SEED = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } misr_state_t;

endpackage

`default_nettype wire

// File: rtl/ccg_misr_step.sv
// ============================================================================
// Module  : ccg_misr_step
// Purpose : Combinational next-signature function of the response MISR.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ccg_misr_step
   import ccg_harness_pkg::*;
#(
   parameter int               OUT_W = ccg_harness_pkg::OUT_W,
   parameter int               SIG_W = ccg_harness_pkg::SIG_W,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
   input  logic [SIG_W-1:0] sig,
   input  logic [OUT_W-1:0] data,
   output logic [SIG_W-1:0] next_sig
);

   logic [SIG_W-1:0] data_ext;
   logic [SIG_W-1:0] feedback;

   always_comb begin
      data_ext             = '0;
      data_ext[OUT_W-1:0]  = data;
   end

   // Polynomial feedback is applied only when a one leaves the MSB.
   assign feedback = sig[SIG_W-1] ? POLY : '0;
   assign next_sig = {sig[SIG_W-2:0], 1'b0} ^ feedback ^ data_ext;

endmodule

`default_nettype wire

// File: rtl/ccg_resp_misr.sv
// ============================================================================
// Module  : ccg_resp_misr
// Purpose : Counts and compacts response beats into a MISR, then compares.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ccg_resp_misr
   import ccg_harness_pkg::*;
#(
   parameter int               OUT_W = 18,
   parameter int               SIG_W = 32,
   parameter logic [SIG_W-1:0] POLY  = 32'h04C1_1DB7,
   parameter logic [SIG_W-1:0] SEED  = 32'h0000_0000,
   parameter int               CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_pat,
   input  logic [SIG_W-1:0] exp_sig,
   input  logic             f_valid,
   input  logic [OUT_W-1:0] f_data,
   output logic             f_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] count
);

   misr_state_t      state_q,   state_d;
   logic [SIG_W-1:0] sig_q,     sig_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [CNT_W-1:0] npat_q,    npat_d;
   logic [SIG_W-1:0] exp_q,     exp_d;
   logic             pass_q,    pass_d;

   logic [SIG_W-1:0] step_sig;
   logic [CNT_W-1:0] cnt_inc;
   logic             xfer;

   ccg_misr_step #(
      .OUT_W (OUT_W),
      .SIG_W (SIG_W),
      .POLY  (POLY)
   ) u_step (
      .sig      (sig_q),
      .data     (f_data),
      .next_sig (step_sig)
   );

   assign cnt_inc = cnt_q + CNT_W'(1);
   assign xfer    = f_valid && (state_q == ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         npat_q  <= '0;
         exp_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         npat_q  <= npat_d;
         exp_q   <= exp_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      npat_d  = npat_q;
      exp_d   = exp_q;
      pass_d  = pass_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               sig_d  = SEED;
               cnt_d  = '0;
               npat_d = num_pat;
               exp_d  = exp_sig;
               // An empty run completes at once against the seed itself.
               if (num_pat == '0) begin
                  state_d = ST_DONE;
                  pass_d  = (SEED == exp_sig);
               end else begin
                  state_d = ST_RUN;
                  pass_d  = 1'b0;
               end
            end
         end

         ST_RUN: begin
            if (xfer) begin
               sig_d = step_sig;
               cnt_d = cnt_inc;
               if (cnt_inc == npat_q) begin
                  state_d = ST_DONE;
                  pass_d  = (step_sig == exp_q);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            pass_d  = 1'b0;
         end
      endcase
   end

   assign f_ready   = (state_q == ST_RUN);
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign pass      = pass_q && (state_q == ST_DONE);
   assign signature = sig_q;
   assign count     = cnt_q;

endmodule

`default_nettype wire

// File: doc/ccg_resp_misr.md
# ccg_resp_misr

Sequential response compactor placed directly downstream of a combinational CCGRCG benchmark netlist. It accepts the netlist's 18-bit output vector (f1..f18) once per valid beat and folds each beat into a 32-bit multiple-input signature register (MISR). It counts a programmed number of patterns, then freezes the signature and compares it against an expected value. Together with an upstream stimulus driver it forms the self-checking harness that wraps each generated benchmark for dataset validation.

## Interface
Parameters:
- OUT_W, 18, width of the compacted response vector; f1 maps to bit 0.
- SIG_W, 32, MISR width; must be ≥ OUT_W.
- POLY, 32'h04C1_1DB7, feedback polynomial used when the MSB shifts out.
- SEED, 32'h0000_0000, signature value loaded on start.
- CNT_W, 16, width of the pattern counter.

Ports:
- Clock and reset (already decided): one clock, `clk`; reset `rst_n`, asynchronous, active-low.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse; begins a run. Honoured only in IDLE or DONE.
- num_pat, in, CNT_W, number of beats to compact; sampled on start.
- exp_sig, in, SIG_W, golden signature; sampled on start.
- f_valid, in, 1, response beat is valid.
- f_data, in, OUT_W, response vector {f18..f1}.
- f_ready, out, 1, block accepts the beat; high only in RUN.
- busy, out, 1, high in RUN.
- done, out, 1, high in DONE; held until the next start.
- pass, out, 1, signature == exp_sig; valid while done is high, 0 otherwise.
- signature, out, SIG_W, current MISR value.
- count, out, CNT_W, beats accepted in the current run.

## Operation
- States: IDLE, RUN, DONE (encoding is an enum in the package).
- IDLE/DONE + start:
  - num_pat != 0 → RUN: signature ← SEED, count ← 0, capture num_pat and exp_sig.
  - num_pat == 0 → DONE directly: signature ← SEED; pass = (SEED == exp_sig).
- RUN: a beat transfers when f_valid & f_ready.
  - On transfer: signature ← {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended f_data; count ← count+1.
  - On the transfer where count+1 == num_pat → DONE.
- Without a transfer, signature and count hold.
- DONE: signature, count, pass are frozen; f_ready = 0.
- start in RUN is ignored; the run is not restarted.
- count never wraps: the maximum num_pat is 2^CNT_W−1.

## Timing
- Reset values: state IDLE, signature SEED, count 0, f_ready 0, busy 0, done 0, pass 0.
- Asynchronous reset mid-run aborts immediately to the reset values; the partial signature is lost.
- start to RUN: 1 cycle. f_ready rises the cycle after start.
- Beat latency: signature and count reflect a transferred beat on the next edge.
- done rises on the edge of the last transfer. pass is registered on the same edge from the next-signature value, so it is valid coincident with done.
- f_ready depends on state only, with no combinational path from f_valid.
- Throughput is 1 beat per cycle.

## Structure
- Package `ccg_harness_pkg`: state enum, default POLY/SEED constants, OUT_W constant. Shared with the upstream stimulus driver.
- One sub-module `ccg_misr_step`: purely combinational next-signature function (sig, data → next). Reused by the golden-signature generator in the bench.
- Top contains the FSM, counter, capture registers and comparator.

## Test plan
- Reset: assert rst_n=0 mid-run after 3 beats → all outputs at reset values. f_ready=0 the same cycle, without waiting for a clock edge.
- Single beat: SEED=0, num_pat=1, f_data=18'h00001 → signature 32'h0000_0001, count 1, done=1. With exp_sig=32'h1, pass=1.
- Shift/feedback: num_pat=33; beat 1 = 18'h1, then 32 beats of 0 → after 31 zeros the signature is 32'h8000_0000, and the final value is 32'h04C1_1DB7.
- Backpressure/gaps: num_pat=4 with f_valid toggling 1,0,1,0,1,1 → exactly 4 transfers. The signature matches `ccg_misr_step` applied 4 times; f_valid while in DONE has no effect.
- num_pat=0 with exp_sig=SEED → DONE the next cycle, pass=1, no f_ready pulse.
- start during RUN plus a mismatching exp_sig: the start pulse at beat 2 of 5 is ignored and the run completes 5 beats. With exp_sig off by one bit, done=1 and pass=0. A second start from DONE restarts with count 0.
